keypad_key_player: RTL and testbench

- Synthesizable keypad emulator: the row-driving end of the 4x4 matrix keypad interface.
- Accepts queued key codes over a valid/ready handshake and "presses" each key on the matrix.
- For each press, drives row from the scanner's col strobes, including contact bounce on press and release, a hold period, and an inter-key gap.
- Used to drive the security-system scanner in system sims and on FPGA self-test builds.

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/keypad_key_fifo.sv | 54 +++++
 rtl/keypad_key_player.sv | 138 +++++++++++++
 tb/tb_keypad_key_player.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: FSM encoding, key layout and
// the code-to-matrix-position decode.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  localparam int KEY_ROW_HI = 3;
  localparam int KEY_ROW_LO = 2;
  localparam int KEY_COL_HI = 1;
  localparam int KEY_COL_LO = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_BOUNCE_IN  = 3'd1;
  localparam state_t ST_HOLD       = 3'd2;
  localparam state_t ST_BOUNCE_OUT = 3'd3;
  localparam state_t ST_GAP        = 3'd4;

  // Physical layout of the 4x4 pad, code = row*4 + col
  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_8    = 4'd9;
  localparam logic [3:0] KEY_9    = 4'd10;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_0    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  function automatic key_pos_t decode_key(input logic [3:0] code);
    key_pos_t pos;
    pos.row = code[KEY_ROW_HI:KEY_ROW_LO];
    pos.col = code[KEY_COL_HI:KEY_COL_LO];
    return pos;
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Small synchronous FIFO holding queued key codes; reset flushes it.
module keypad_key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/keypad_key_player.sv
// Row-driving end of a 4x4 matrix keypad: plays queued key codes as presses
// with contact bounce, hold and inter-key gap.
module keypad_key_player #(
  parameter int DEPTH         = 8,
  parameter int BOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int GAP_CYCLES    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic                   key_ready,
  input  logic [3:0]             col,
  output logic [3:0]             row,
  output logic                   pressed,
  output logic                   busy,
  output logic                   key_done,
  output logic [$clog2(DEPTH):0] count
);

  import keypad_pkg::*;

  localparam int CNT_MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_BH > GAP_CYCLES) ? CNT_MAX_BH : GAP_CYCLES;
  localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] CNT_ONE     = 1;
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam bit            HAS_BOUNCE  = (BOUNCE_CYCLES > 0);

  state_t         state;
  state_t         state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic           pressed_n;
  logic           pop;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [3:0]     fifo_rdata;
  key_pos_t       key_pos;

  assign key_ready = !fifo_full;
  assign push      = key_valid && key_ready;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  keypad_key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (key_code),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Every transition clears cnt so each phase counts from zero.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_ONE;
    pop      = 1'b0;
    key_done = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
        end
      end
      ST_BOUNCE_IN: begin
        if (cnt == BOUNCE_LAST) begin
          state_n = ST_HOLD;
          cnt_n   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
          cnt_n   = '0;
        end
      end
      ST_BOUNCE_OUT: begin
        if (cnt == BOUNCE_LAST) begin
          state_n = ST_GAP;
          cnt_n   = '0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n  = ST_IDLE;
          cnt_n    = '0;
          key_done = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Contact bounces closed-first on press and open-first on release.
  always_comb begin
    pressed_n = 1'b0;
    case (state_n)
      ST_BOUNCE_IN:  pressed_n = ~cnt_n[0];
      ST_HOLD:       pressed_n = 1'b1;
      ST_BOUNCE_OUT: pressed_n = cnt_n[0];
      default:       pressed_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pressed <= 1'b0;
      key_pos <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pressed <= pressed_n;
      if (pop) key_pos <= decode_key(fifo_rdata);
    end
  end

  assign row = (pressed && col[key_pos.col]) ? (4'b0001 << key_pos.row) : 4'b0000;

endmodule

// File: tb/tb_keypad_key_player.sv
// Self-checking bench for keypad_key_player: directed scenarios plus random
// traffic, checked against a phase-timeline model of each key press.
module tb_keypad_key_player;

  import keypad_pkg::*;

  localparam int DEPTH  = 8;
  localparam int B      = 4;
  localparam int H      = 16;
  localparam int G      = 8;
  localparam int ACTIVE = 2*B + H + G;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] col;
  logic [3:0] row;
  logic       pressed;
  logic       busy;
  logic       key_done;
  logic [3:0] count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int accepts     = 0;
  int done_seen   = 0;
  int done_cycles[$];

  logic [3:0] model_q[$];
  int         phase = -1;
  logic [3:0] cur_key = 4'd0;

  keypad_key_player #(
    .DEPTH         (DEPTH),
    .BOUNCE_CYCLES (B),
    .HOLD_CYCLES   (H),
    .GAP_CYCLES    (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .col       (col),
    .row       (row),
    .pressed   (pressed),
    .busy      (busy),
    .key_done  (key_done),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Contact state at a given offset after the pop edge.
  function automatic bit contact(input int o);
    if (o < B)         return (o % 2) == 0;
    if (o < B + H)     return 1'b1;
    if (o < 2*B + H)   return ((o - B - H) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic checkAll();
    bit         exp_pressed;
    logic [3:0] exp_row;
    exp_pressed = (phase >= 0) && contact(phase);
    exp_row     = (exp_pressed && col[cur_key[1:0]]) ? (4'b0001 << cur_key[3:2]) : 4'b0000;
    checkOutput("pressed",   {31'd0, pressed},   {31'd0, exp_pressed});
    checkOutput("row",       {28'd0, row},       {28'd0, exp_row});
    checkOutput("key_done",  {31'd0, key_done},  {31'd0, (phase == ACTIVE - 1)});
    checkOutput("busy",      {31'd0, busy},      {31'd0, (model_q.size() > 0) || (phase >= 0)});
    checkOutput("count",     {28'd0, count},     32'(model_q.size()));
    checkOutput("key_ready", {31'd0, key_ready}, {31'd0, (model_q.size() < DEPTH)});
    if (key_done === 1'b1) begin
      done_seen++;
      done_cycles.push_back(cyc);
    end
  endtask

  task automatic modelEdge(input logic r, input logic v, input logic [3:0] code);
    int pre;
    if (r) begin
      model_q.delete();
      phase = -1;
      return;
    end
    pre = model_q.size();
    if (phase < 0) begin
      if (pre > 0) begin
        cur_key = model_q.pop_front();
        phase   = 0;
      end
    end else if (phase == ACTIVE - 1) begin
      phase = -1;
    end else begin
      phase++;
    end
    if (v && pre < DEPTH) model_q.push_back(code);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] code, input logic [3:0] c);
    rst       = r;
    key_valid = v;
    key_code  = code;
    col       = c;
    #1;
    checkAll();
    if (!r && v && key_ready === 1'b1) accepts++;
    @(posedge clk);
    modelEdge(r, v, code);
    cyc++;
    #1;
  endtask

  initial begin
    logic [3:0] gate_cols[6];
    logic [3:0] gate_rows[6];
    logic [3:0] pin[4];
    logic [3:0] hold_keys[4];

    gate_cols = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0000};
    gate_rows = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    pin       = '{KEY_1, KEY_9, KEY_4, KEY_HASH};
    hold_keys = '{KEY_2, KEY_3, KEY_6, KEY_7};

    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; col = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);

    $display("[TB] single key KEY_5");
    done_seen = 0;
    applyStimulus(1'b0, 1'b1, KEY_5, 4'b0010);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'b0010);
    checkOutput("single_done_count", 32'(done_seen), 32'd1);

    $display("[TB] column gating");
    applyStimulus(1'b0, 1'b1, KEY_5, 4'b0010);
    for (int i = 0; i < B + 1; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'b0010);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, gate_cols[i]);
      checkOutput("gate_row", {28'd0, row}, {28'd0, gate_rows[i]});
    end
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'b1111);

    $display("[TB] PIN sequence");
    accepts = 0; done_seen = 0; done_cycles.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, pin[i], 4'b1111);
    checkOutput("pin_accepts", 32'(accepts), 32'd4);
    for (int i = 0; i < 4*33 + 6; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'b1111);
    checkOutput("pin_done_count", 32'(done_seen), 32'd4);
    for (int i = 0; i + 1 < done_cycles.size(); i++)
      checkOutput("pin_done_spacing", 32'(done_cycles[i+1] - done_cycles[i]), 32'd33);

    $display("[TB] full FIFO");
    accepts = 0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 4'(accepts), 4'b1111);
    checkOutput("full_accepts", 32'(accepts), 32'd9);
    checkOutput("full_count", {28'd0, count}, 32'd8);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 4'(accepts), 4'b1111);
    checkOutput("full_accepts_after_pop", 32'(accepts), 32'd10);

    $display("[TB] reset mid-traffic");
    applyStimulus(1'b1, 1'b1, 4'd3, 4'b1111);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'b1111);
    checkOutput("rst_row",     {28'd0, row},       32'd0);
    checkOutput("rst_pressed", {31'd0, pressed},   32'd0);
    checkOutput("rst_ready",   {31'd0, key_ready}, 32'd1);
    checkOutput("rst_busy",    {31'd0, busy},      32'd0);
    checkOutput("rst_count",   {28'd0, count},     32'd0);

    $display("[TB] reset mid-HOLD");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, hold_keys[i], 4'b1111);
    for (int i = 0; i < 40; i++) begin
      if (phase == B + 9) break;
      applyStimulus(1'b0, 1'b0, 4'd0, 4'b1111);
    end
    checkOutput("reach_hold10", 32'(phase), 32'(B + 9));
    checkOutput("hold_queued", {28'd0, count}, 32'd3);
    done_seen = 0;
    applyStimulus(1'b1, 1'b0, 4'd0, 4'b1111);
    checkOutput("hrst_row",   {28'd0, row},   32'd0);
    checkOutput("hrst_count", {28'd0, count}, 32'd0);
    checkOutput("hrst_busy",  {31'd0, busy},  32'd0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'b1111);
    checkOutput("hrst_no_done", 32'(done_seen), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++)
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
